gray_scale_ctrl_master: RTL and testbench
=========================================

# gray_scale_ctrl_master

AXI4-Lite initiator that drives the `s_axi_CONTROL_BUS` slave port of `gray_scale_top`. It lets fabric logic run frames without the processor. For each accepted command it:
- programs the frame argument,
- enables the done interrupt and starts the core,
- waits on `interrupt`,
- acknowledges the interrupt and checks the idle bit,
- reports a completion status.

It sits between a frame scheduler and the filter's control bus.

## Interface
Parameters:
- `C_M_AXI_CONTROL_BUS_ADDR_WIDTH`, default 5: control bus address width.
- `C_M_AXI_CONTROL_BUS_DATA_WIDTH`, default 32: control bus data width. Only 32 is supported.
- `C_TIMEOUT_CYCLES`, default 1048576: maximum number of cycles spent waiting for `interrupt`.

Ports (clock and reset first):
- `aclk`  in  1  single clock for all logic.
- `areset`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  start-frame request.
- `cmd_ready`  out  1  block is idle and accepts a command.
- `cmd_arg`  in  32  value written to the argument register 0x10.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_status`  out  2  completion code: 00 ok, 01 timeout, 10 bus error, 11 core not idle.
- `busy`  out  1  high from command accept until `done_valid`.
- `m_axi_CONTROL_BUS_AWADDR`/`AWVALID` out, `AWREADY` in.
- `m_axi_CONTROL_BUS_WDATA` (32)/`WSTRB` (4)/`WVALID` out, `WREADY` in.
- `m_axi_CONTROL_BUS_BRESP` (2)/`BVALID` in, `BREADY` out.
- `m_axi_CONTROL_BUS_ARADDR`/`ARVALID` out, `ARREADY` in.
- `m_axi_CONTROL_BUS_RDATA` (32)/`RRESP` (2)/`RVALID` in, `RREADY` out.
- `interrupt`  in  1  level interrupt from the core.

## Operation
Slave register map:

| Address | Register | Use |
|---|---|---|
| 0x00 | ap_ctrl | bit0 ap_start, bit1 ap_done, bit2 ap_idle |
| 0x04 | GIE | global interrupt enable |
| 0x08 | IER | interrupt enable |
| 0x0C | ISR | toggle-on-write |
| 0x10 | argument | frame argument |

State machine:
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`: latch `cmd_arg`, clear the error flag, go to WR_ARG.
- **Write states**, in order:
  - WR_ARG: address 0x10, data = arg.
  - WR_GIE: 0x04, data 1.
  - WR_IER: 0x08, data 1.
  - WR_START: 0x00, data 1.
- **WAIT_IRQ**
  - Timeout counter is cleared on entry and increments each cycle.
  - `interrupt`=1: go to RD_ISR.
  - Counter reaches `C_TIMEOUT_CYCLES`-1 with no interrupt: status 01, go to DONE.
- **RD_ISR**: read 0x0C.
- **WR_ISR**: write 0x0C with data = captured `RDATA` & 32'h3, which toggles the set bits clear.
- **RD_CTRL**
  - Read 0x00.
  - Status 00 if `RDATA[2]`=1, else 11.
- **DONE**: `done_valid`=1 for one cycle, then return to IDLE.

Bus-level rules:
- Write transaction:
  - `AWVALID` and `WVALID` rise in the same cycle with stable address and data.
  - Each drops independently in the cycle after its own handshake.
  - `BREADY` rises once both handshakes are complete and holds until `BVALID`.
  - Only then does the FSM advance.
- `WSTRB` = 4'hF always.
- Read transaction:
  - `ARVALID` is held until `ARREADY`.
  - `RREADY` is then held until `RVALID`, and `RDATA` is captured on that cycle.
- Bus errors:
  - `BRESP` or `RRESP` ≠ 00 on any transaction: finish that transaction, skip all remaining ones, status 10, go to DONE.
  - Error takes priority over all other codes.
- `interrupt` during any write state is ignored. It is sampled only in WAIT_IRQ.
- `done_status` holds its value until the next `done_valid`.

## Timing
- Reset values:
  - All VALID/READY outputs 0, `cmd_ready` 0, `busy` 0, `done_valid` 0, `done_status` 00.
  - `AWADDR`/`ARADDR`/`WDATA` 0.
  - State IDLE.
  - `cmd_ready` goes to 1 on the first clock edge after reset is released.
- All outputs are registered. There is no combinational path from slave inputs to master outputs.
- Each write takes at least 3 cycles (AW/W, B, advance) with a zero-wait slave. Each read takes at least 3 cycles.
- Latency from command accept to `done_valid` with a zero-wait slave: 4 writes + read + write + read + 2 = fixed 23 cycles, plus the interrupt wait.
- `busy` is high from the cycle after accept through the `done_valid` cycle.
- Reset asserted mid-transaction:
  - Immediately drop all VALID/READY and return to IDLE.
  - No `done_valid`.
- A command presented while busy is held off (`cmd_ready`=0) and never dropped.

## Test plan
- **Nominal run.** Zero-wait slave model; `cmd_arg`=0x0000_01E0; interrupt 50 cycles after the write to 0x00; RD_CTRL returns 0x4.
  - Required write order: 0x10=0x1E0, 0x04=1, 0x08=1, 0x00=1, 0x0C=ISR&3.
  - `done_status`=00.
- **Backpressure.** `AWREADY` 3 cycles late and `WREADY` 5 cycles late on every write.
  - Each VALID stays high until its own handshake.
  - Address and data stay stable while waiting.
  - Final result identical to the nominal run.
- **Timeout.** `C_TIMEOUT_CYCLES`=64, interrupt never asserted.
  - `done_valid` exactly 64 cycles after WAIT_IRQ entry, `done_status`=01.
  - No further bus transactions.
- **Bus error.** `BRESP`=2'b10 on the 0x04 write.
  - No transactions to 0x08 or 0x00.
  - `done_status`=10.
- **Core not idle.** RD_CTRL returns 0x0 → `done_status`=11.
- **Reset mid-operation.** Command accepted; reset asserted during the 0x08 write with `AWVALID`=1.
  - All outputs reach their reset values asynchronously.
  - A second command afterwards completes with status 00.

Source files
------------

// File: rtl/gray_scale_ctrl_master.sv
// AXI4-Lite initiator that runs one gray_scale_top frame per accepted command:
// program argument, enable irq, start, wait for irq, ack ISR, check ap_idle.
module gray_scale_ctrl_master #(
    parameter int C_M_AXI_CONTROL_BUS_ADDR_WIDTH = 5,
    parameter int C_M_AXI_CONTROL_BUS_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES               = 1048576
) (
    input  logic                                        aclk,
    input  logic                                        areset,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [31:0]                                 cmd_arg,
    output logic                                        done_valid,
    output logic [1:0]                                  done_status,
    output logic                                        busy,
    output logic [C_M_AXI_CONTROL_BUS_ADDR_WIDTH-1:0]   m_axi_CONTROL_BUS_AWADDR,
    output logic                                        m_axi_CONTROL_BUS_AWVALID,
    input  logic                                        m_axi_CONTROL_BUS_AWREADY,
    output logic [C_M_AXI_CONTROL_BUS_DATA_WIDTH-1:0]   m_axi_CONTROL_BUS_WDATA,
    output logic [3:0]                                  m_axi_CONTROL_BUS_WSTRB,
    output logic                                        m_axi_CONTROL_BUS_WVALID,
    input  logic                                        m_axi_CONTROL_BUS_WREADY,
    input  logic [1:0]                                  m_axi_CONTROL_BUS_BRESP,
    input  logic                                        m_axi_CONTROL_BUS_BVALID,
    output logic                                        m_axi_CONTROL_BUS_BREADY,
    output logic [C_M_AXI_CONTROL_BUS_ADDR_WIDTH-1:0]   m_axi_CONTROL_BUS_ARADDR,
    output logic                                        m_axi_CONTROL_BUS_ARVALID,
    input  logic                                        m_axi_CONTROL_BUS_ARREADY,
    input  logic [C_M_AXI_CONTROL_BUS_DATA_WIDTH-1:0]   m_axi_CONTROL_BUS_RDATA,
    input  logic [1:0]                                  m_axi_CONTROL_BUS_RRESP,
    input  logic                                        m_axi_CONTROL_BUS_RVALID,
    output logic                                        m_axi_CONTROL_BUS_RREADY,
    input  logic                                        interrupt
);

    localparam int AW = C_M_AXI_CONTROL_BUS_ADDR_WIDTH;
    localparam int DW = C_M_AXI_CONTROL_BUS_DATA_WIDTH;
    localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0] ADDR_CTRL = AW'(5'h00);
    localparam logic [AW-1:0] ADDR_GIE  = AW'(5'h04);
    localparam logic [AW-1:0] ADDR_IER  = AW'(5'h08);
    localparam logic [AW-1:0] ADDR_ISR  = AW'(5'h0C);
    localparam logic [AW-1:0] ADDR_ARG  = AW'(5'h10);
    localparam logic [CW-1:0] TMO_LAST  = CW'(C_TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_TMO  = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;
    localparam logic [1:0] ST_BUSY = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ARG, S_WR_GIE, S_WR_IER, S_WR_START,
        S_WAIT_IRQ, S_RD_ISR, S_WR_ISR, S_RD_CTRL, S_DONE
    } state_t;

    // Every bus state walks REQ (address/data) -> RESP (B or R) -> ADV.
    typedef enum logic [1:0] {PH_REQ, PH_RESP, PH_ADV} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [DW-1:0]   arg_q, arg_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      stat_q, stat_d;
    logic            err_q, err_d;
    logic            awvalid_q, awvalid_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic            wvalid_q, wvalid_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic            rready_q, rready_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            busy_q, busy_d;
    logic            done_valid_q, done_valid_d;
    logic [1:0]      done_status_q, done_status_d;
    logic            launch;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        arg_d         = arg_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        stat_d        = stat_q;
        err_d         = err_q;
        awvalid_d     = awvalid_q;
        awaddr_d      = awaddr_q;
        wvalid_d      = wvalid_q;
        wdata_d       = wdata_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        rready_d      = rready_q;
        done_status_d = done_status_q;
        launch        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    arg_d   = DW'(cmd_arg);
                    err_d   = 1'b0;
                    stat_d  = ST_OK;
                    state_d = S_WR_ARG;
                    launch  = 1'b1;
                end
            end
            S_WR_ARG, S_WR_GIE, S_WR_IER, S_WR_START, S_WR_ISR: begin
                case (phase_q)
                    PH_REQ: begin
                        if (awvalid_q && m_axi_CONTROL_BUS_AWREADY) awvalid_d = 1'b0;
                        if (wvalid_q && m_axi_CONTROL_BUS_WREADY)   wvalid_d  = 1'b0;
                        if (!awvalid_d && !wvalid_d) begin
                            bready_d = 1'b1;
                            phase_d  = PH_RESP;
                        end
                    end
                    PH_RESP: begin
                        if (m_axi_CONTROL_BUS_BVALID) begin
                            bready_d = 1'b0;
                            if (m_axi_CONTROL_BUS_BRESP != 2'b00) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                phase_d = PH_ADV;
                            end
                        end
                    end
                    default: begin
                        launch = 1'b1;
                        case (state_q)
                            S_WR_ARG: state_d = S_WR_GIE;
                            S_WR_GIE: state_d = S_WR_IER;
                            S_WR_IER: state_d = S_WR_START;
                            S_WR_START: state_d = S_WAIT_IRQ;
                            default: state_d = S_RD_CTRL;
                        endcase
                    end
                endcase
            end
            S_WAIT_IRQ: begin
                cnt_d = cnt_q + 1'b1;
                if (interrupt) begin
                    state_d = S_RD_ISR;
                    launch  = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    stat_d  = ST_TMO;
                    state_d = S_DONE;
                end
            end
            S_RD_ISR, S_RD_CTRL: begin
                case (phase_q)
                    PH_REQ: begin
                        if (m_axi_CONTROL_BUS_ARREADY) begin
                            arvalid_d = 1'b0;
                            rready_d  = 1'b1;
                            phase_d   = PH_RESP;
                        end
                    end
                    PH_RESP: begin
                        if (m_axi_CONTROL_BUS_RVALID) begin
                            rready_d = 1'b0;
                            rdata_d  = m_axi_CONTROL_BUS_RDATA;
                            if (m_axi_CONTROL_BUS_RRESP != 2'b00) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                if (state_q == S_RD_CTRL)
                                    stat_d = m_axi_CONTROL_BUS_RDATA[2] ? ST_OK : ST_BUSY;
                                phase_d = PH_ADV;
                            end
                        end
                    end
                    default: begin
                        if (state_q == S_RD_ISR) begin
                            state_d = S_WR_ISR;
                            launch  = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                endcase
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Entering a bus state raises its VALIDs together with stable address/data.
        if (launch) begin
            phase_d = PH_REQ;
            cnt_d   = '0;
            case (state_d)
                S_WR_ARG:   begin awvalid_d = 1'b1; wvalid_d = 1'b1; awaddr_d = ADDR_ARG;  wdata_d = arg_d; end
                S_WR_GIE:   begin awvalid_d = 1'b1; wvalid_d = 1'b1; awaddr_d = ADDR_GIE;  wdata_d = DW'(1); end
                S_WR_IER:   begin awvalid_d = 1'b1; wvalid_d = 1'b1; awaddr_d = ADDR_IER;  wdata_d = DW'(1); end
                S_WR_START: begin awvalid_d = 1'b1; wvalid_d = 1'b1; awaddr_d = ADDR_CTRL; wdata_d = DW'(1); end
                S_WR_ISR:   begin awvalid_d = 1'b1; wvalid_d = 1'b1; awaddr_d = ADDR_ISR;  wdata_d = rdata_q & DW'(3); end
                S_RD_ISR:   begin arvalid_d = 1'b1; araddr_d = ADDR_ISR; end
                S_RD_CTRL:  begin arvalid_d = 1'b1; araddr_d = ADDR_CTRL; end
                default: ;
            endcase
        end

        done_valid_d = (state_d == S_DONE) && (state_q != S_DONE);
        if (done_valid_d) done_status_d = err_d ? ST_ERR : stat_d;
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= S_IDLE;
            phase_q       <= PH_REQ;
            arg_q         <= '0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            stat_q        <= ST_OK;
            err_q         <= 1'b0;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            wvalid_q      <= 1'b0;
            wdata_q       <= '0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= ST_OK;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            arg_q         <= arg_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
            stat_q        <= stat_d;
            err_q         <= err_d;
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            wvalid_q      <= wvalid_d;
            wdata_q       <= wdata_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
        end
    end

    assign cmd_ready                 = cmd_ready_q;
    assign busy                      = busy_q;
    assign done_valid                = done_valid_q;
    assign done_status               = done_status_q;
    assign m_axi_CONTROL_BUS_AWADDR  = awaddr_q;
    assign m_axi_CONTROL_BUS_AWVALID = awvalid_q;
    assign m_axi_CONTROL_BUS_WDATA   = wdata_q;
    assign m_axi_CONTROL_BUS_WSTRB   = 4'hF;
    assign m_axi_CONTROL_BUS_WVALID  = wvalid_q;
    assign m_axi_CONTROL_BUS_BREADY  = bready_q;
    assign m_axi_CONTROL_BUS_ARADDR  = araddr_q;
    assign m_axi_CONTROL_BUS_ARVALID = arvalid_q;
    assign m_axi_CONTROL_BUS_RREADY  = rready_q;

endmodule

// File: tb/tb_gray_scale_ctrl_master.sv
// Scoreboard bench: a slave model answers the control bus, a negedge monitor
// pops expected writes/reads/completions and compares.
module tb_gray_scale_ctrl_master;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, done_valid, busy;
    logic [31:0] cmd_arg;
    logic [1:0]  done_status;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, interrupt;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    gray_scale_ctrl_master #(.C_TIMEOUT_CYCLES(64)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_arg(cmd_arg),
        .done_valid(done_valid), .done_status(done_status), .busy(busy),
        .m_axi_CONTROL_BUS_AWADDR(awaddr), .m_axi_CONTROL_BUS_AWVALID(awvalid),
        .m_axi_CONTROL_BUS_AWREADY(awready),
        .m_axi_CONTROL_BUS_WDATA(wdata), .m_axi_CONTROL_BUS_WSTRB(wstrb),
        .m_axi_CONTROL_BUS_WVALID(wvalid), .m_axi_CONTROL_BUS_WREADY(wready),
        .m_axi_CONTROL_BUS_BRESP(bresp), .m_axi_CONTROL_BUS_BVALID(bvalid),
        .m_axi_CONTROL_BUS_BREADY(bready),
        .m_axi_CONTROL_BUS_ARADDR(araddr), .m_axi_CONTROL_BUS_ARVALID(arvalid),
        .m_axi_CONTROL_BUS_ARREADY(arready),
        .m_axi_CONTROL_BUS_RDATA(rdata), .m_axi_CONTROL_BUS_RRESP(rresp),
        .m_axi_CONTROL_BUS_RVALID(rvalid), .m_axi_CONTROL_BUS_RREADY(rready),
        .interrupt(interrupt)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    // slave configuration, set by the stimulus block
    int          aw_dly = 0, w_dly = 0, irq_dly = 50, err_addr = -1;
    logic [31:0] ctrl_val = 32'h4;

    // scoreboard
    logic [36:0] exp_wr[$];
    logic [4:0]  exp_rd[$];
    logic [1:0]  exp_done[$];
    int n_vec = 0, n_err = 0;
    int done_cnt = 0, tmo_req = 0, tmo_ack = 0, empty_req = 0, empty_ack = 0;
    int lat_chk = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // ---------------- slave model: drives inputs 1 time unit after each edge
    logic        s_awg, s_wg, s_rpend, s_arm;
    int          s_awc, s_wc, s_irqc;
    logic [4:0]  s_addr, s_raddr, p_awaddr, p_araddr;
    logic [31:0] s_data, s_isr, p_wdata;
    logic        p_awv, p_wv, p_bready, p_arv, p_rready;

    always @(posedge aclk) begin
        #1;
        if (areset) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
            rvalid = 0; rdata = 0; rresp = 0; interrupt = 0;
            s_awg = 0; s_wg = 0; s_rpend = 0; s_arm = 0; s_awc = 0; s_wc = 0;
            s_irqc = 0; s_isr = 0; s_addr = 0; s_data = 0; s_raddr = 0;
            p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
            p_awaddr = 0; p_araddr = 0; p_wdata = 0;
        end else begin
            if (p_awv && awready) begin s_awg = 1; s_addr = p_awaddr; end
            if (p_wv && wready)   begin s_wg = 1;  s_data = p_wdata;  end
            if (bvalid && p_bready) bvalid = 0;
            if (p_arv && arready) begin s_rpend = 1; s_raddr = p_araddr; end
            if (rvalid && p_rready) rvalid = 0;
            if (s_arm) begin
                if (s_irqc == irq_dly) begin s_isr[0] = 1'b1; s_arm = 0; end
                else s_irqc++;
            end
            awready = 0;
            if (awvalid && !s_awg) begin if (s_awc >= aw_dly) awready = 1; else s_awc++; end
            wready = 0;
            if (wvalid && !s_wg) begin if (s_wc >= w_dly) wready = 1; else s_wc++; end
            if (s_awg && s_wg && !bvalid) begin
                bvalid = 1;
                bresp  = (int'(s_addr) == err_addr) ? 2'b10 : 2'b00;
                if (s_addr == 5'h00 && s_data[0] && irq_dly >= 0) begin s_arm = 1; s_irqc = 0; end
                if (s_addr == 5'h0C) s_isr[1:0] = s_isr[1:0] ^ s_data[1:0];
                s_awg = 0; s_wg = 0; s_awc = 0; s_wc = 0;
            end
            interrupt = s_isr[0];
            arready = arvalid && !s_rpend && !rvalid;
            if (s_rpend) begin
                rvalid  = 1;
                rresp   = 0;
                rdata   = (s_raddr == 5'h0C) ? s_isr : (s_raddr == 5'h00) ? ctrl_val : 32'h0;
                s_rpend = 0;
            end
            p_awv = awvalid; p_awaddr = awaddr; p_wv = wvalid; p_wdata = wdata;
            p_bready = bready; p_arv = arvalid; p_araddr = araddr; p_rready = rready;
        end
    end

    // ---------------- monitor / checker
    logic [4:0]  m_addr, q_awaddr;
    logic [31:0] m_data, q_wdata;
    logic        q_awv, q_awr, q_wv, q_wr;
    logic [1:0]  last_status;
    int          since_rst = 0, start_b_cyc = 0;

    always @(negedge aclk or posedge areset) begin
        if (areset) begin
            #1;
            chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
            chk("rst_ctl", {cmd_ready, busy, done_valid, done_status}, 0);
            chk("rst_addr", {awaddr, araddr}, 0);
            chk("rst_wdata", wdata, 0);
            since_rst = 0; last_status = 0;
            q_awv = 0; q_awr = 0; q_wv = 0; q_wr = 0; q_awaddr = 0; q_wdata = 0;
            m_addr = 0; m_data = 0;
        end else begin
            since_rst++;
            if (since_rst == 1) chk("rdy_in_reset_cycle", cmd_ready, 0);
            if (since_rst == 2) chk("rdy_after_reset", cmd_ready, 1);
            if (since_rst >= 2) chk("busy_vs_ready", busy, !cmd_ready);
            if (since_rst >= 2 && !done_valid) chk("status_hold", done_status, last_status);
            if (awvalid && !q_awv) chk("aw_w_rise_together", {wvalid, q_wv}, 2'b10);
            if (q_awv && !q_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, q_awaddr});
            if (q_wv && !q_wr)   chk("w_hold", {wvalid, wdata}, {1'b1, q_wdata});
            if (awvalid && awready) m_addr = awaddr;
            if (wvalid && wready) begin m_data = wdata; chk("wstrb", wstrb, 4'hF); end
            if (bvalid && bready) begin
                if (exp_wr.size() == 0) flag($sformatf("unexpected write 0x%0h=0x%0h", m_addr, m_data));
                else chk("write", {m_addr, m_data}, exp_wr.pop_front());
                if (m_addr == 5'h00) start_b_cyc = cyc;
            end
            if (arvalid && arready) begin
                if (exp_rd.size() == 0) flag($sformatf("unexpected read 0x%0h", araddr));
                else chk("read_addr", araddr, exp_rd.pop_front());
            end
            if (done_valid) begin
                if (exp_done.size() == 0) flag("unexpected done_valid");
                else chk("done_status", done_status, exp_done.pop_front());
                chk("busy_at_done", busy, 1);
                if (lat_chk != 0) chk("timeout_latency", cyc - start_b_cyc, 66);
                last_status = done_status;
                done_cnt++;
            end
            if (tmo_req != tmo_ack) begin flag("wait bound expired"); tmo_ack = tmo_req; end
            if (empty_req != empty_ack) begin
                chk("scoreboard_drained", {exp_wr.size(), exp_rd.size(), exp_done.size()}, 0);
                empty_ack = empty_req;
            end
            q_awv = awvalid; q_awr = awready; q_awaddr = awaddr;
            q_wv = wvalid; q_wr = wready; q_wdata = wdata;
        end
    end

    // ---------------- stimulus
    task automatic push_writes(input logic [31:0] a, input int n);
        logic [36:0] w[5];
        w[0] = {5'h10, a}; w[1] = {5'h04, 32'h1}; w[2] = {5'h08, 32'h1};
        w[3] = {5'h00, 32'h1}; w[4] = {5'h0C, 32'h1};
        for (int i = 0; i < n; i++) exp_wr.push_back(w[i]);
    endtask

    task automatic push_frame(input logic [31:0] a, input logic [1:0] st);
        push_writes(a, 5);
        exp_rd.push_back(5'h0C);
        exp_rd.push_back(5'h00);
        exp_done.push_back(st);
    endtask

    task automatic send(input logic [31:0] a);
        int k = 0;
        @(negedge aclk);
        cmd_valid = 1; cmd_arg = a;
        while (!cmd_ready && k < 3000) begin @(negedge aclk); k++; end
        if (k >= 3000) tmo_req++;
        @(posedge aclk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 3000) begin @(negedge aclk); k++; end
        if (done_cnt < target) tmo_req++;
        repeat (4) @(negedge aclk);
        empty_req++;
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        int k;
        areset = 1; cmd_valid = 0; cmd_arg = 0;
        repeat (3) @(posedge aclk);
        #2 areset = 0;
        repeat (3) @(negedge aclk);

        // nominal frame
        push_frame(32'h1E0, 2'b00);
        send(32'h1E0);
        wait_done(1);

        // backpressure, second command presented while busy
        aw_dly = 3; w_dly = 5;
        push_frame(32'h1E0, 2'b00);
        push_frame(32'h2A5, 2'b00);
        send(32'h1E0);
        send(32'h2A5);
        wait_done(3);
        aw_dly = 0; w_dly = 0;

        // core not idle
        ctrl_val = 32'h0;
        push_frame(32'h77, 2'b11);
        send(32'h77);
        wait_done(4);
        ctrl_val = 32'h4;

        // bus error on the GIE write
        err_addr = 4;
        push_writes(32'h5, 2);
        exp_done.push_back(2'b10);
        send(32'h5);
        wait_done(5);
        err_addr = -1;

        // timeout: interrupt never comes
        irq_dly = -1; lat_chk = 1;
        push_writes(32'h9, 4);
        exp_done.push_back(2'b01);
        send(32'h9);
        wait_done(6);
        irq_dly = 50; lat_chk = 0;

        // reset during the IER write
        aw_dly = 3;
        push_writes(32'hABC, 2);
        send(32'hABC);
        k = 0;
        while (!(awvalid && awaddr == 5'h08) && k < 500) begin @(negedge aclk); k++; end
        if (k >= 500) tmo_req++;
        #2 areset = 1;
        repeat (2) @(posedge aclk);
        #2 areset = 0;
        repeat (6) @(negedge aclk);
        empty_req++;
        repeat (2) @(negedge aclk);
        aw_dly = 0;
        push_frame(32'h1E0, 2'b00);
        send(32'h1E0);
        wait_done(7);

        repeat (3) @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
